// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
// Runs one SD-card SPI-mode command transaction on top of a byte-level SPI
// controller: builds the 6-byte command frame (with serially computed CRC7),
// writes it, polls for R1, optionally reads a 4-byte R3/R7 payload, issues 8
// trailing clocks with CS still asserted, then reports the result.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   host command handshake (ready only in IDLE)
//   cmd_index/arg/long    command index, argument, 1 = read 4 payload bytes
//   resp_valid            one-cycle completion pulse
//   resp_r1/data/timeout  captured R1 (0xFF on timeout), payload, timeout flag
//   busy                  high whenever a transaction is in flight
//   cs_n                  card chip-select, active-low
//   spi_start/op/size     SPI controller request (op 1 = write, size = n-1)
//   spi_done              SPI controller completion pulse
//   spi_address/wr/rx     SPI controller byte address, RX strobe, RX byte
//   spi_tx_byte           frame byte at spi_address (0xFF past the frame)
module sd_cmd_sequencer #(
    parameter int MEMORY_SIZE_IN_BYTES = 64,
    parameter int MAX_POLL             = 8,
    parameter int AW                   = $clog2(MEMORY_SIZE_IN_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [5:0]    cmd_index,
    input  logic [31:0]   cmd_arg,
    input  logic          cmd_long,
    output logic          resp_valid,
    output logic [7:0]    resp_r1,
    output logic [31:0]   resp_data,
    output logic          resp_timeout,
    output logic          busy,
    output logic          cs_n,
    output logic          spi_start,
    output logic          spi_op,
    output logic [AW-1:0] spi_size,
    input  logic          spi_done,
    input  logic [AW-1:0] spi_address,
    input  logic          spi_wr,
    input  logic [7:0]    spi_rx_byte,
    output logic [7:0]    spi_tx_byte
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CRC       = 4'd1;
    localparam logic [3:0] S_TX_GO     = 4'd2;
    localparam logic [3:0] S_TX_WAIT   = 4'd3;
    localparam logic [3:0] S_POLL_GO   = 4'd4;
    localparam logic [3:0] S_POLL_WAIT = 4'd5;
    localparam logic [3:0] S_DATA_GO   = 4'd6;
    localparam logic [3:0] S_DATA_WAIT = 4'd7;
    localparam logic [3:0] S_TAIL_GO   = 4'd8;
    localparam logic [3:0] S_TAIL_WAIT = 4'd9;
    localparam logic [3:0] S_DONE      = 4'd10;

    logic [3:0]  state_q, state_d;
    logic        cs_n_q, cs_n_d;
    logic [39:0] frame_q, frame_d;     // bytes 0..4, byte 0 in [39:32]
    logic [7:0]  byte5_q, byte5_d;     // {crc7, stop bit}
    logic [6:0]  crc_q, crc_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic        long_q, long_d;
    logic [7:0]  resp_r1_q, resp_r1_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_timeout_q, resp_timeout_d;

    logic        crc_in;
    logic [6:0]  crc_nxt;
    logic [7:0]  r1_now;

    // Serial CRC7 (x^7 + x^3 + 1), one frame bit per cycle, MSB first.
    always_comb begin
        crc_in  = frame_q[6'd39 - bit_cnt_q] ^ crc_q[6];
        crc_nxt = {crc_q[5:0], 1'b0} ^ (crc_in ? 7'h09 : 7'h00);
    end

    // A strobe coinciding with spi_done still counts for the R1 decision.
    assign r1_now = spi_wr ? spi_rx_byte : resp_r1_q;

    always_comb begin
        state_d        = state_q;
        cs_n_d         = cs_n_q;
        frame_d        = frame_q;
        byte5_d        = byte5_q;
        crc_d          = crc_q;
        bit_cnt_d      = bit_cnt_q;
        poll_cnt_d     = poll_cnt_q;
        long_d         = long_q;
        resp_r1_d      = resp_r1_q;
        resp_data_d    = resp_data_q;
        resp_timeout_d = resp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    frame_d        = {2'b01, cmd_index, cmd_arg};
                    long_d         = cmd_long;
                    crc_d          = 7'd0;
                    bit_cnt_d      = 6'd0;
                    poll_cnt_d     = 8'd0;
                    cs_n_d         = 1'b0;
                    resp_r1_d      = 8'hFF;
                    resp_data_d    = 32'd0;
                    resp_timeout_d = 1'b0;
                    state_d        = S_CRC;
                end
            end
            S_CRC: begin
                crc_d     = crc_nxt;
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd39) begin
                    byte5_d = {crc_nxt, 1'b1};
                    state_d = S_TX_GO;
                end
            end
            S_TX_GO:   state_d = S_TX_WAIT;
            S_TX_WAIT: if (spi_done) state_d = S_POLL_GO;
            S_POLL_GO: begin
                poll_cnt_d = poll_cnt_q + 8'd1;
                state_d    = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (spi_wr) resp_r1_d = spi_rx_byte;
                if (spi_done) begin
                    if (!r1_now[7]) begin
                        state_d = long_q ? S_DATA_GO : S_TAIL_GO;
                    end else if (poll_cnt_q == 8'(MAX_POLL)) begin
                        resp_timeout_d = 1'b1;
                        resp_r1_d      = 8'hFF;
                        state_d        = S_TAIL_GO;
                    end else begin
                        state_d = S_POLL_GO;
                    end
                end
            end
            S_DATA_GO: state_d = S_DATA_WAIT;
            S_DATA_WAIT: begin
                // Big-endian: first received byte lands in [31:24].
                if (spi_wr) begin
                    case (spi_address[1:0])
                        2'd0:    resp_data_d[31:24] = spi_rx_byte;
                        2'd1:    resp_data_d[23:16] = spi_rx_byte;
                        2'd2:    resp_data_d[15:8]  = spi_rx_byte;
                        default: resp_data_d[7:0]   = spi_rx_byte;
                    endcase
                end
                if (spi_done) state_d = S_TAIL_GO;
            end
            S_TAIL_GO: state_d = S_TAIL_WAIT;
            S_TAIL_WAIT: begin
                if (spi_done) begin
                    cs_n_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cs_n_q         <= 1'b1;
            frame_q        <= {40{1'b1}};
            byte5_q        <= 8'hFF;
            crc_q          <= 7'd0;
            bit_cnt_q      <= 6'd0;
            poll_cnt_q     <= 8'd0;
            long_q         <= 1'b0;
            resp_r1_q      <= 8'hFF;
            resp_data_q    <= 32'd0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cs_n_q         <= cs_n_d;
            frame_q        <= frame_d;
            byte5_q        <= byte5_d;
            crc_q          <= crc_d;
            bit_cnt_q      <= bit_cnt_d;
            poll_cnt_q     <= poll_cnt_d;
            long_q         <= long_d;
            resp_r1_q      <= resp_r1_d;
            resp_data_q    <= resp_data_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    // SPI request fields decode from state, so op/size stay stable from the
    // GO cycle through the matching WAIT state.
    always_comb begin
        spi_start = 1'b0;
        spi_op    = 1'b0;
        spi_size  = '0;
        case (state_q)
            S_TX_GO:     begin spi_start = 1'b1; spi_op = 1'b1; spi_size = AW'(5); end
            S_TX_WAIT:   begin spi_op = 1'b1; spi_size = AW'(5); end
            S_POLL_GO,
            S_TAIL_GO:   spi_start = 1'b1;
            S_DATA_GO:   begin spi_start = 1'b1; spi_size = AW'(3); end
            S_DATA_WAIT: spi_size = AW'(3);
            default:     ;
        endcase
    end

    always_comb begin
        case (spi_address)
            AW'(0):  spi_tx_byte = frame_q[39:32];
            AW'(1):  spi_tx_byte = frame_q[31:24];
            AW'(2):  spi_tx_byte = frame_q[23:16];
            AW'(3):  spi_tx_byte = frame_q[15:8];
            AW'(4):  spi_tx_byte = frame_q[7:0];
            AW'(5):  spi_tx_byte = byte5_q;
            default: spi_tx_byte = 8'hFF;
        endcase
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign resp_valid   = (state_q == S_DONE);
    assign cs_n         = cs_n_q;
    assign resp_r1      = resp_r1_q;
    assign resp_data    = resp_data_q;
    assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
module tb_sd_cmd_sequencer;

    localparam int MEM      = 64;
    localparam int MAX_POLL = 8;
    localparam int AW       = $clog2(MEM);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [5:0]    cmd_index;
    logic [31:0]   cmd_arg;
    logic          cmd_long;
    logic          resp_valid;
    logic [7:0]    resp_r1;
    logic [31:0]   resp_data;
    logic          resp_timeout;
    logic          busy;
    logic          cs_n;
    logic          spi_start;
    logic          spi_op;
    logic [AW-1:0] spi_size;
    logic          spi_done;
    logic [AW-1:0] spi_address;
    logic          spi_wr;
    logic [7:0]    spi_rx_byte;
    logic [7:0]    spi_tx_byte;

    int tests = 0;
    int fails = 0;
    logic [7:0] last_b5;

    sd_cmd_sequencer #(.MEMORY_SIZE_IN_BYTES(MEM), .MAX_POLL(MAX_POLL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .cmd_long(cmd_long),
        .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_data(resp_data),
        .resp_timeout(resp_timeout), .busy(busy), .cs_n(cs_n),
        .spi_start(spi_start), .spi_op(spi_op), .spi_size(spi_size),
        .spi_done(spi_done), .spi_address(spi_address), .spi_wr(spi_wr),
        .spi_rx_byte(spi_rx_byte), .spi_tx_byte(spi_tx_byte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of polynomial long division of msg * x^7 by 0x89.
    function automatic logic [6:0] crc7_div(input logic [39:0] msg);
        logic [46:0] v;
        v = {msg, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v = v ^ (47'h89 << (i - 7));
        return v[6:0];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic [31:0] arg, input int i);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        if (i < 5) return m[39 - 8*i -: 8];
        return {crc7_div(m), 1'b1};
    endfunction

    // One full transaction; the bench plays the SPI controller and the card.
    // nfail = number of 0xFF polls before R1 appears (>= MAX_POLL -> timeout).
    task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                           input int nfail, input logic [7:0] r1, input logic [31:0] pay,
                           input bit hold, input bit abort);
        bit got;
        int npoll, nxfer, nx, k, cyc, wt, seq_err, busy_viol;
        bit xfer, seen_rv;
        logic cur_op;
        logic [AW-1:0] cur_sz, exp_sz;
        logic exp_op;
        logic [7:0] txb [6];
        got   = (nfail < MAX_POLL);
        npoll = got ? nfail + 1 : MAX_POLL;
        nxfer = 2 + npoll + ((got && lng) ? 1 : 0);
        for (int i = 0; i < 6; i++) txb[i] = 8'h00;

        wt = 0;
        while (!cmd_ready && wt < 100) begin @(negedge clk); wt++; end
        chk("ready_when_idle", 32'(wt), 32'd0);
        cmd_valid = 1'b1; cmd_index = idx; cmd_arg = arg; cmd_long = lng;
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        chk("accept_cs_low", {31'd0, cs_n}, 32'd0);
        chk("accept_busy", {busy, cmd_ready}, 32'b10);

        xfer = 0; nx = 0; k = 0; cyc = 0; seq_err = 0; busy_viol = 0; seen_rv = 0;
        cur_op = 0; cur_sz = '0;
        while (cyc < 3000) begin
            if (resp_valid) begin seen_rv = 1; break; end
            if (cmd_ready !== 1'b0 || cs_n !== 1'b0 || busy !== 1'b1) busy_viol++;
            spi_wr = 1'b0; spi_done = 1'b0;
            if (!xfer) begin
                if (spi_start) begin
                    xfer = 1; k = 0; cur_op = spi_op; cur_sz = spi_size;
                    exp_op = (nx == 0);
                    exp_sz = (nx == 0) ? AW'(5) : (got && lng && nx == npoll + 1) ? AW'(3) : AW'(0);
                    if (nx >= nxfer || cur_op !== exp_op || cur_sz !== exp_sz) seq_err++;
                end
            end else begin
                if (spi_op !== cur_op || spi_size !== cur_sz || spi_start !== 1'b0) seq_err++;
                if (abort && nx == 1) begin
                    rst_n = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    chk("abort_cs_n", {31'd0, cs_n}, 32'd1);
                    chk("abort_busy", {31'd0, busy}, 32'd0);
                    chk("abort_start", {31'd0, spi_start}, 32'd0);
                    chk("abort_no_valid", {31'd0, resp_valid}, 32'd0);
                    chk("abort_r1", {24'd0, resp_r1}, 32'hFF);
                    rst_n = 1'b1;
                    @(negedge clk);
                    return;
                end
                if (k <= int'(cur_sz)) begin
                    spi_address = AW'(k);
                    if (cur_op) begin
                        #1;
                        if (nx == 0 && k < 6) txb[k] = spi_tx_byte;
                    end else begin
                        spi_wr = 1'b1;
                        if (nx >= 1 && nx <= npoll)
                            spi_rx_byte = (got && nx == npoll) ? r1 : 8'hFF;
                        else if (got && lng && nx == npoll + 1)
                            spi_rx_byte = pay[31 - 8*k -: 8];
                        else
                            spi_rx_byte = 8'($urandom);
                    end
                    k++;
                end else begin
                    spi_done = 1'b1; xfer = 0; nx++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        spi_wr = 1'b0; spi_done = 1'b0;
        chk("resp_valid_seen", {31'd0, seen_rv}, 32'd1);
        chk("xfer_count", 32'(nx), 32'(nxfer));
        chk("xfer_sequence", 32'(seq_err), 32'd0);
        chk("cs_low_ready_low_while_busy", 32'(busy_viol), 32'd0);
        for (int i = 0; i < 6; i++) chk($sformatf("tx_byte%0d", i), {24'd0, txb[i]}, {24'd0, frame_byte(idx, arg, i)});
        last_b5 = txb[5];
        chk("resp_r1", {24'd0, resp_r1}, got ? {24'd0, r1} : 32'hFF);
        chk("resp_timeout", {31'd0, resp_timeout}, {31'd0, !got});
        chk("resp_data", resp_data, (got && lng) ? pay : 32'd0);
        chk("cs_high_at_done", {31'd0, cs_n}, 32'd1);
        @(negedge clk);
        chk("resp_valid_one_cycle", {31'd0, resp_valid}, 32'd0);
        chk("resp_r1_held", {24'd0, resp_r1}, got ? {24'd0, r1} : 32'hFF);
        chk("resp_data_held", resp_data, (got && lng) ? pay : 32'd0);
        chk("idle_after_done", {busy, cmd_ready}, 32'b01);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_long = 1'b0;
        spi_done = 1'b0; spi_address = '0; spi_wr = 1'b0; spi_rx_byte = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("rst_busy_ready", {busy, cmd_ready}, 32'b01);
        chk("rst_start", {31'd0, spi_start}, 32'd0);
        chk("rst_op_size", {25'd0, spi_op, spi_size}, 32'd0);
        chk("rst_resp", {resp_valid, resp_timeout, resp_r1}, 32'h0FF);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_frame", {24'd0, spi_tx_byte}, 32'hFF);
        rst_n = 1'b1;
        @(negedge clk);

        // cmd_valid while busy must not disturb the transaction (held below).
        run_txn(6'd0, 32'h0, 1'b0, 1, 8'h01, 32'h0, 1'b0, 1'b0);
        chk("cmd0_crc", {24'd0, last_b5}, 32'h95);
        run_txn(6'd8, 32'h000001AA, 1'b1, 0, 8'h01, 32'h000001AA, 1'b0, 1'b0);
        chk("cmd8_crc", {24'd0, last_b5}, 32'h87);
        run_txn(6'd58, 32'h0, 1'b1, 20, 8'h00, 32'hDEADBEEF, 1'b0, 1'b0);

        // Out-of-frame addresses read as 0xFF.
        for (int i = 0; i < 4; i++) begin
            spi_address = AW'($urandom_range(6, 63));
            #1;
            chk("tx_addr_out_of_frame", {24'd0, spi_tx_byte}, 32'hFF);
        end
        @(negedge clk);

        run_txn(6'd17, 32'h0, 1'b0, 0, 8'h00, 32'h0, 1'b0, 1'b0);
        chk("cmd17_crc", {24'd0, last_b5}, 32'h55);

        // cmd_valid held high: second accept immediately after DONE.
        run_txn(6'd55, 32'h0, 1'b0, 2, 8'h01, 32'h0, 1'b1, 1'b0);
        run_txn(6'd55, 32'h0, 1'b0, 0, 8'h00, 32'h0, 1'b0, 1'b0);

        // Reset during a poll, then a normal CMD0.
        run_txn(6'd0, 32'h0, 1'b0, 3, 8'h01, 32'h0, 1'b0, 1'b1);
        run_txn(6'd0, 32'h0, 1'b0, 1, 8'h01, 32'h0, 1'b0, 1'b0);

        // Randomized transactions, including timeout and long responses.
        for (int n = 0; n < 8; n++)
            run_txn(6'($urandom), $urandom, 1'($urandom), $urandom_range(0, 10),
                    {1'b0, 7'($urandom)}, $urandom, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
